// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared types for the cache request bridge.
//   CACHE_WIDTH / CACHE_RAM_DEPTH : default data width and address space of
//                                   the cache port; the request entry below
//                                   is sized from them.
//   cache_req_t                   : one queued request (we, addr, data).
//   bridge_state_t                : bridge FSM states.
// ---------------------------------------------------------------------------
package cache_pkg;

  localparam int CACHE_WIDTH     = 8;
  localparam int CACHE_RAM_DEPTH = 256;
  localparam int CACHE_AW        = $clog2(CACHE_RAM_DEPTH);

  typedef struct packed {
    logic                   we;
    logic [CACHE_AW-1:0]    addr;
    logic [CACHE_WIDTH-1:0] data;
  } cache_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } bridge_state_t;

endpackage

// File: rtl/req_fifo.sv
// ---------------------------------------------------------------------------
// req_fifo
// Synchronous FIFO of cache_req_t entries with a combinational head view.
// Ports:
//   clk      : clock
//   rst      : synchronous active-low reset (flushes the FIFO)
//   push_i   : write din_i (ignored when full, even if popping this cycle)
//   din_i    : entry to enqueue
//   pop_i    : discard the head entry (ignored when empty)
//   dout_o   : current head entry
//   full_o   : no free slot
//   empty_o  : no valid entry
// ---------------------------------------------------------------------------
module req_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  cache_req_t din_i,
  input  logic       pop_i,
  output cache_req_t dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PW = $clog2(DEPTH);

  cache_req_t mem_q [DEPTH];
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  // Extra MSB on the pointers distinguishes full from empty; wrap is natural.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign wr_ptr_d = wr_ptr_q + (PW+1)'(do_push);
  assign rd_ptr_d = rd_ptr_q + (PW+1)'(do_pop);

  // The head is registered into the issue registers by the consumer, so a
  // combinational read of this small array keeps the one-cycle latency.
  assign dout_o = mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/cache_req_bridge.sv
// ---------------------------------------------------------------------------
// cache_req_bridge
// Queues requests from a valid/ready stream, issues them one at a time to the
// cache CPU-side port (level-held we/re until a done pulse or a timeout) and
// returns one response per request, in order, on a valid/ready stream.
// Ports:
//   clk, rst                  : clock, synchronous active-low reset
//   req_valid/req_ready       : request handshake (ready = FIFO not full)
//   req_we/req_addr/req_data  : request payload
//   rsp_valid/rsp_ready       : response handshake (held until accepted)
//   rsp_is_write/rsp_data/rsp_err : response payload (err = timed out)
//   we/re/addr/data_in        : cache command, held until done
//   done/data_out             : cache completion pulse and read data
//   timeout_seen              : sticky timeout flag, cleared by reset only
// The queue entry type is sized from the cache_pkg constants; retarget those
// together with WIDTH/RAM_DEPTH.
// ---------------------------------------------------------------------------
module cache_req_bridge
  import cache_pkg::*;
#(
  parameter int  WIDTH          = CACHE_WIDTH,
  parameter int  RAM_DEPTH      = CACHE_RAM_DEPTH,
  parameter int  REQ_DEPTH      = 4,
  parameter int  TIMEOUT_CYCLES = 64,
  localparam int AW             = $clog2(RAM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_is_write,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             we,
  output logic             re,
  output logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] data_in,
  input  logic             done,
  input  logic [WIDTH-1:0] data_out,
  output logic             timeout_seen
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  bridge_state_t    state_q;
  logic             we_q, re_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] data_in_q;
  logic             rsp_valid_q, rsp_is_write_q, rsp_err_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             timeout_seen_q;
  logic [TW-1:0]    tcnt_q;

  cache_req_t fifo_din;
  cache_req_t fifo_head;
  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic       timeout_hit;

  // Gated with rst so the stream sees "not ready" for the whole reset window.
  assign req_ready = rst && !fifo_full;
  assign fifo_push = req_valid && req_ready;
  assign fifo_din  = {req_we, req_addr, req_data};
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

  req_fifo #(
    .DEPTH (REQ_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign timeout_hit = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      we_q           <= 1'b0;
      re_q           <= 1'b0;
      addr_q         <= '0;
      data_in_q      <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_is_write_q <= 1'b0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      timeout_seen_q <= 1'b0;
      tcnt_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q   <= ISSUE;
            addr_q    <= fifo_head.addr;
            data_in_q <= fifo_head.we ? fifo_head.data : '0;
            we_q      <= fifo_head.we;
            re_q      <= !fifo_head.we;
            tcnt_q    <= '0;
          end
        end
        ISSUE: begin
          // done is checked first so a completion on the last allowed cycle
          // still returns good data.
          if (done) begin
            state_q        <= RESP;
            we_q           <= 1'b0;
            re_q           <= 1'b0;
            rsp_valid_q    <= 1'b1;
            rsp_is_write_q <= we_q;
            rsp_data_q     <= we_q ? '0 : data_out;
            rsp_err_q      <= 1'b0;
          end else if (timeout_hit) begin
            state_q        <= RESP;
            we_q           <= 1'b0;
            re_q           <= 1'b0;
            rsp_valid_q    <= 1'b1;
            rsp_is_write_q <= we_q;
            rsp_data_q     <= '0;
            rsp_err_q      <= 1'b1;
            timeout_seen_q <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign we           = we_q;
  assign re           = re_q;
  assign addr         = addr_q;
  assign data_in      = data_in_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_is_write = rsp_is_write_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign timeout_seen = timeout_seen_q;

endmodule

// File: tb/tb_cache_req_bridge.sv
// ---------------------------------------------------------------------------
// tb_cache_req_bridge
// Drives the bridge against a behavioural cache model with programmable done
// latency (0 = never completes). Expected responses are queued at request
// acceptance and compared in order as responses are handed off.
// ---------------------------------------------------------------------------
module tb_cache_req_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_data;
  logic       rsp_valid, rsp_ready, rsp_is_write, rsp_err;
  logic [7:0] rsp_data;
  logic       we, re, done, timeout_seen;
  logic [7:0] addr, data_in, data_out;

  cache_req_bridge #(
    .WIDTH          (8),
    .RAM_DEPTH      (256),
    .REQ_DEPTH      (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_is_write (rsp_is_write),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .we           (we),
    .re           (re),
    .addr         (addr),
    .data_in      (data_in),
    .done         (done),
    .data_out     (data_out),
    .timeout_seen (timeout_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t       sb [$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_err = 0;
  int         n_rsp = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] cmem    [256];
  int         lat = 1;
  logic       stray_en = 1'b0;
  int         run = 0;
  int         last_run = 0;
  int         strobe_total = 0;
  int         proto_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cache model: counts strobe cycles at negedge, pulses done on cycle 'lat'.
  always @(negedge clk) begin
    if (!rst) begin
      run  = 0;
      done = 1'b0;
    end else if (we || re) begin
      if (we && re) proto_err++;
      run++;
      strobe_total++;
      if (lat != 0 && run == lat) begin
        done = 1'b1;
        if (we) cmem[addr] = data_in;
        else    data_out   = cmem[addr];
      end else begin
        done = stray_en;
      end
    end else begin
      if (run != 0) last_run = run;
      run  = 0;
      done = stray_en;
      if (stray_en) data_out = 8'hEE;
    end
  end

  // Response monitor: compare each handed-off response with the queue head.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        $display("rsp %0d: is_write=%0b data=0x%02h err=%0b", n_rsp, rsp_is_write, rsp_data, rsp_err);
        chk("rsp_is_write", 32'(rsp_is_write), 32'(mon_e.w));
        chk("rsp_data", 32'(rsp_data), 32'(mon_e.d));
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.e));
        n_rsp++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic exp_err, input bit track);
    bit   acc;
    int   waited;
    exp_t e;
    acc = 1'b0;
    waited = 0;
    req_valid = 1'b1;
    req_we    = w;
    req_addr  = a;
    req_data  = d;
    while (!acc && waited < 100) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    req_valid = 1'b0;
    if (!acc) begin
      chk("push_accept", 32'd0, 32'd1);
    end else if (track) begin
      e.w = w;
      e.e = exp_err;
      if (w) begin
        e.d = 8'h00;
        if (!exp_err) ref_mem[a] = d;
      end else begin
        e.d = exp_err ? 8'h00 : ref_mem[a];
      end
      sb.push_back(e);
      $display("req: we=%0b addr=0x%02h data=0x%02h expect_err=%0b", w, a, d, exp_err);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || rsp_valid || we || re) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'd0, 32'd1);
    tick(2);
  endtask

  initial begin
    int         st0;
    logic       w;
    logic [7:0] a, d;

    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'h00;
      cmem[i]    = 8'h00;
    end
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'h00;
    req_data  = 8'h00;
    rsp_ready = 1'b1;
    data_out  = 8'h00;

    // Reset state
    tick(3);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_we_re", 32'({we, re}), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_timeout_seen", 32'(timeout_seen), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    tick(1);

    // Write then read back
    lat = 3;
    push_req(1'b1, 8'h12, 8'hA5, 1'b0, 1'b1);
    push_req(1'b0, 8'h12, 8'h00, 1'b0, 1'b1);
    drain();

    // Mixed traffic at two latencies
    for (int l = 1; l <= 5; l += 4) begin
      lat = l;
      for (int i = 0; i < 6; i++) begin
        w = 1'($urandom_range(0, 1));
        a = 8'h50 + 8'($urandom_range(0, 7));
        d = 8'($urandom);
        push_req(w, a, d, 1'b0, 1'b1);
      end
      drain();
    end

    // Burst into a stalled response path: FIFO must fill
    lat = 2;
    rsp_ready = 1'b0;
    push_req(1'b1, 8'h20, 8'h01, 1'b0, 1'b1);
    push_req(1'b1, 8'h21, 8'h02, 1'b0, 1'b1);
    push_req(1'b0, 8'h20, 8'h00, 1'b0, 1'b1);
    push_req(1'b1, 8'h20, 8'h03, 1'b0, 1'b1);
    push_req(1'b0, 8'h21, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk("full_req_ready", 32'(req_ready), 32'd0);
    tick(3);
    @(negedge clk);
    chk("full_req_ready_hold", 32'(req_ready), 32'd0);
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain();
    chk("burst_count", 32'(sb.size()), 32'd0);

    // Timeout: cache never completes
    lat = 0;
    push_req(1'b1, 8'h31, 8'h77, 1'b1, 1'b1);
    drain();
    chk("timeout_we_len", 32'(last_run), 32'd8);
    chk("timeout_seen", 32'(timeout_seen), 32'd1);
    lat = 2;
    push_req(1'b0, 8'h31, 8'h00, 1'b0, 1'b1);
    drain();

    // done on the final allowed cycle wins over the timeout
    lat = 8;
    push_req(1'b0, 8'h12, 8'h00, 1'b0, 1'b1);
    drain();
    chk("race_len", 32'(last_run), 32'd8);

    // Stray done while idle
    stray_en = 1'b1;
    tick(1);
    stray_en = 1'b0;
    tick(3);
    @(negedge clk);
    chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("stray_we_re", 32'({we, re}), 32'd0);
    tick(1);

    // Reset while a read is outstanding with two entries queued
    lat = 0;
    push_req(1'b0, 8'h40, 8'h00, 1'b0, 1'b0);
    push_req(1'b0, 8'h41, 8'h00, 1'b0, 1'b0);
    push_req(1'b0, 8'h42, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("midop_re", 32'(re), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midop_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midop_we_re", 32'({we, re}), 32'd0);
    chk("midop_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midop_timeout_seen", 32'(timeout_seen), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    lat = 3;
    st0 = strobe_total;
    tick(20);
    @(negedge clk);
    chk("midop_no_issue", 32'(strobe_total - st0), 32'd0);
    chk("midop_no_rsp", 32'(rsp_valid), 32'd0);
    tick(1);

    // Still functional after reset
    push_req(1'b1, 8'h60, 8'h3C, 1'b0, 1'b1);
    push_req(1'b0, 8'h60, 8'h00, 1'b0, 1'b1);
    drain();

    chk("both_strobes", 32'(proto_err), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule
